// File: rtl/register_file_bank.sv
// rtl/register_file_bank.sv - parametrised register file, one write port, two registered read ports
//
// Purpose:
//   DEPTH x WIDTH storage with a single write port and two read ports.
//   Each read port has its own output register, loaded together under readEn.
//   The storage is built from enable-gated, synchronously reset words.
//   ZERO_REG makes entry 0 read-only, and entry 0 always reads as zero.
//   BYPASS forwards a same-edge write to a read of the same address.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous active-high clear of storage and outputs
//   regWrite   in   write enable
//   writeReg   in   write address (ADDR_W)
//   writeData  in   write data (WIDTH)
//   readEn     in   load enable for both read output registers
//   readReg1   in   read address, port 1 (ADDR_W)
//   readReg2   in   read address, port 2 (ADDR_W)
//   readData1  out  registered read data, port 1 (WIDTH)
//   readData2  out  registered read data, port 2 (WIDTH)

module register_file_bank #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2
);

  // Address range checks use one extra bit, so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;

  logic wr_ok;
  logic rd1_in_range;
  logic rd2_in_range;

  always_comb begin
    // A write counts only if it lands on a real, writable entry.
    // The bypass path uses this same qualifier, so a dropped write is never forwarded.
    wr_ok = regWrite
            && ({1'b0, writeReg} < DEPTH_W)
            && !((ZERO_REG != 0) && (writeReg == '0));
    rd1_in_range = ({1'b0, readReg1} < DEPTH_W);
    rd2_in_range = ({1'b0, readReg2} < DEPTH_W);
  end

  always_comb begin
    rd1_d = rd1_q;
    if (readEn) begin
      if (!rd1_in_range) begin
        rd1_d = '0;
      end else if ((ZERO_REG != 0) && (readReg1 == '0)) begin
        rd1_d = '0;
      end else if ((BYPASS != 0) && wr_ok && (writeReg == readReg1)) begin
        rd1_d = writeData;
      end else begin
        rd1_d = mem_q[readReg1];
      end
    end
  end

  always_comb begin
    rd2_d = rd2_q;
    if (readEn) begin
      if (!rd2_in_range) begin
        rd2_d = '0;
      end else if ((ZERO_REG != 0) && (readReg2 == '0)) begin
        rd2_d = '0;
      end else if ((BYPASS != 0) && wr_ok && (writeReg == readReg2)) begin
        rd2_d = writeData;
      end else begin
        rd2_d = mem_q[readReg2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[writeReg] <= writeData;
      end
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign readData1 = rd1_q;
  assign readData2 = rd2_q;

endmodule

// File: tb/tb_register_file_bank.sv
// tb/tb_register_file_bank.sv - scoreboard bench for register_file_bank in two configurations

module tb_register_file_bank;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        readEn;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] rd1_a, rd2_a;
  logic [31:0] rd1_b, rd2_b;

  int checks;
  int failures;

  // Config 0 is the default (ZERO_REG=1, BYPASS=1, DEPTH=32).
  // Config 1 uses ZERO_REG=0, BYPASS=0, DEPTH=24.
  int          depth_c [2];
  bit          zr_c    [2];
  bit          bp_c    [2];
  logic [31:0] m       [2][32];
  logic [31:0] e1      [2];
  logic [31:0] e2      [2];
  logic [63:0] sb_q    [2][$];

  register_file_bank u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readEn    (readEn),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (rd1_a),
    .readData2 (rd2_a)
  );

  register_file_bank #(
    .WIDTH    (32),
    .ADDR_W   (5),
    .DEPTH    (24),
    .ZERO_REG (0),
    .BYPASS   (0)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readEn    (readEn),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (rd1_b),
    .readData2 (rd2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int c, input logic [4:0] a,
                                           input bit we, input logic [4:0] wa,
                                           input logic [31:0] wd, input bit wdrop);
    if (int'(a) >= depth_c[c]) return 32'h0;
    if (zr_c[c] && a == 5'd0) return 32'h0;
    if (bp_c[c] && we && !wdrop && wa == a) return wd;
    return m[c][a];
  endfunction

  // Drive one cycle, predict both DUTs, then compare after the edge.
  task automatic cycle(input string tag, input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit re, input logic [4:0] a1,
                       input logic [4:0] a2);
    logic [63:0] exp;
    reset = rst; regWrite = we; writeReg = wa; writeData = wd;
    readEn = re; readReg1 = a1; readReg2 = a2;
    for (int c = 0; c < 2; c++) begin
      bit          drop;
      logic [31:0] n1, n2;
      drop = (int'(wa) >= depth_c[c]) || (zr_c[c] && wa == 5'd0);
      if (rst) begin
        n1 = '0; n2 = '0;
      end else if (re) begin
        n1 = model_rd(c, a1, we, wa, wd, drop);
        n2 = model_rd(c, a2, we, wa, wd, drop);
      end else begin
        n1 = e1[c]; n2 = e2[c];
      end
      sb_q[c].push_back({n1, n2});
      e1[c] = n1; e2[c] = n2;
      if (rst) begin
        for (int i = 0; i < 32; i++) m[c][i] = '0;
      end else if (we && !drop) begin
        m[c][wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    exp = sb_q[0].pop_front();
    check_eq({tag, "_a_rd1"}, rd1_a, exp[63:32]);
    check_eq({tag, "_a_rd2"}, rd2_a, exp[31:0]);
    exp = sb_q[1].pop_front();
    check_eq({tag, "_b_rd1"}, rd1_b, exp[63:32]);
    check_eq({tag, "_b_rd2"}, rd2_b, exp[31:0]);
  endtask

  initial begin
    checks = 0; failures = 0;
    depth_c[0] = 32; zr_c[0] = 1'b1; bp_c[0] = 1'b1;
    depth_c[1] = 24; zr_c[1] = 1'b0; bp_c[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      e1[c] = 'x; e2[c] = 'x;
      for (int i = 0; i < 32; i++) m[c][i] = 'x;
    end
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readEn = 1'b0; readReg1 = '0; readReg2 = '0;
    #2;

    cycle("rst0", 1, 0, 0, 0, 0, 0, 0);
    check_eq("rst0_direct", rd1_a, 32'h0);

    // Reset clears everything, even after all entries are preloaded.
    for (int i = 1; i < 32; i++) cycle("preload", 0, 1, 5'(i), 32'hFFFF_FFFF, 0, 0, 0);
    cycle("rst1", 1, 1, 5'd3, 32'h1234_0000, 1, 5'd1, 5'd31);
    check_eq("rst1_after_a1", rd1_a, 32'h0);
    check_eq("rst1_after_a2", rd2_a, 32'h0);
    cycle("rd_1_31", 0, 0, 0, 0, 1, 5'd1, 5'd31);
    check_eq("clr_a_rd1", rd1_a, 32'h0);
    check_eq("clr_a_rd2", rd2_a, 32'h0);

    // Basic write and read.
    cycle("wr5", 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    cycle("wr31", 0, 1, 5'd31, 32'h1234_5678, 0, 0, 0);
    cycle("rd_5_31", 0, 0, 0, 0, 1, 5'd5, 5'd31);
    check_eq("basic_a_rd1", rd1_a, 32'hDEAD_BEEF);
    check_eq("basic_a_rd2", rd2_a, 32'h1234_5678);
    check_eq("basic_b_rd2_oor", rd2_b, 32'h0);

    // Register 0.
    cycle("wr0", 0, 1, 5'd0, 32'hAAAA_AAAA, 0, 0, 0);
    cycle("rd_0_0", 0, 0, 0, 0, 1, 5'd0, 5'd0);
    check_eq("zero_a", rd1_a, 32'h0);
    check_eq("zero_b", rd2_b, 32'hAAAA_AAAA);

    // Bypass versus no bypass.
    cycle("wr7", 0, 1, 5'd7, 32'h1111_1111, 0, 0, 0);
    cycle("byp", 0, 1, 5'd7, 32'h2222_2222, 1, 5'd7, 5'd7);
    check_eq("byp_a", rd2_a, 32'h2222_2222);
    check_eq("byp_b_old", rd1_b, 32'h1111_1111);
    cycle("reread7", 0, 0, 0, 0, 1, 5'd7, 5'd7);
    check_eq("byp_b_new", rd2_b, 32'h2222_2222);

    // Hold while readEn is low.
    cycle("wr9", 0, 1, 5'd9, 32'h0000_ABCD, 0, 0, 0);
    cycle("rd9", 0, 0, 0, 0, 1, 5'd9, 5'd9);
    for (int i = 0; i < 3; i++) cycle("hold", 0, 1, 5'(10 + i), 32'hC0DE_0000 + i, 0, 5'd10, 5'd11);
    check_eq("hold_a", rd1_a, 32'h0000_ABCD);
    check_eq("hold_b", rd1_b, 32'h0000_ABCD);

    // Out-of-range entry on the DEPTH=24 instance.
    cycle("wr28", 0, 1, 5'd28, 32'h0000_0055, 0, 0, 0);
    cycle("rd28", 0, 0, 0, 0, 1, 5'd28, 5'd28);
    check_eq("oor_b", rd1_b, 32'h0);
    check_eq("oor_a", rd1_a, 32'h0000_0055);
    for (int i = 0; i < 24; i += 2) cycle("scan", 0, 0, 0, 0, 1, 5'(i), 5'(i + 1));

    // Random traffic, including occasional mid-sequence resets.
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom),
            $urandom, 1'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
